block_writer_axi: RTL
=====================

# block_writer_axi

Write-back end of the block pipeline: accepts the filtered pixel stream in block order (BLOCK_SIZE×BLOCK_SIZE blocks, row-major inside each block, blocks raster-ordered across the frame) and writes it to frame memory through the AXI write channels, one INCR burst per block row. It sits after the Wiener stage and mirrors the memory-reader/AXI-read-master pair on the read side, restoring raster layout in memory.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, pixel word width (one RGB pixel per word)
- BLOCK_SIZE, 8, block edge in pixels; power of 2, ≤16
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start_frame  in  1  1-cycle pulse, latches base_addr/frame_width/frame_height
- base_addr  in  ADDR_WIDTH  frame byte base address
- frame_width, frame_height  in  16 each  frame size in pixels, multiples of BLOCK_SIZE
- pix_data  in  DATA_WIDTH  input pixel; pix_valid in 1; pix_ready out 1
- awaddr out ADDR_WIDTH; awlen out 8; awsize out 3; awburst out 2; awvalid out 1; awready in 1
- wdata out DATA_WIDTH; wstrb out DATA_WIDTH/8; wlast out 1; wvalid out 1; wready in 1
- bresp in 2; bvalid in 1; bready out 1
- busy  out  1  high from accepted start_frame until frame_done
- frame_done  out  1  1-cycle pulse after final B response
- write_error  out  1  sticky error flag (see Configuration)

## Operation
- States: IDLE, FILL, ADDR, DATA, RESP, DONE.
- IDLE: start_frame accepted only if frame_width ≥ BLOCK_SIZE and frame_height ≥ BLOCK_SIZE; latch inputs, clear counters (r, block_col, block_row), go FILL. start_frame outside IDLE ignored.
- FILL: pix_ready=1; each pix_valid&&pix_ready stores into row buffer[idx]; acceptance of idx=BLOCK_SIZE-1 → ADDR.
- ADDR: awvalid=1, awlen=BLOCK_SIZE-1, awsize=log2(DATA_WIDTH/8) (3'b010), awburst=2'b01; awaddr = base + ((block_row·BLOCK_SIZE + r)·frame_width + block_col·BLOCK_SIZE)·(DATA_WIDTH/8), 32-bit arithmetic truncated to ADDR_WIDTH. awvalid&&awready → DATA.
- DATA: wvalid=1, wdata=buffer[beat], wstrb all ones, wlast when beat=BLOCK_SIZE-1. Beat advances on wready; last beat handshake → RESP.
- RESP: bready=1; on bvalid: r++; if r wrapped → block_col++; if block_col wrapped (= frame_width/BLOCK_SIZE) → block_row++; if block_row wraps (= frame_height/BLOCK_SIZE) → DONE else → FILL.
- DONE: frame_done=1 for one cycle, busy drops, → IDLE.
- AXI rules: awvalid/wvalid, once high, stay high with stable awaddr/wdata/wlast until handshake. wvalid never asserted before AW handshake. Exactly one outstanding burst.

## Timing
- Reset: all outputs 0 (awburst=0, awlen=0, awsize=0, wstrb=0), state IDLE, counters and write_error cleared. Reset mid-burst abandons the burst immediately; no recovery handshake.
- start_frame at cycle T → busy and pix_ready high at T+1.
- Last FILL pixel accepted at cycle t → awvalid high at t+1.
- AW handshake at cycle a → wvalid high at a+1; with wready tied high, wlast at a+BLOCK_SIZE.
- wlast handshake at cycle w → bready high at w+1; bvalid accepted same cycle bready high.
- bvalid accepted at cycle b → pix_ready at b+1 (next row) or frame_done at b+1 (last row).
- Best-case per row: BLOCK_SIZE + 1 + BLOCK_SIZE + 1 cycles; 16×16 frame, BLOCK_SIZE=8: 32 bursts.

## Configuration
- WRITER_BRESP_CHECK_EN defined: bresp≠2'b00 on accepted B response sets write_error (sticky until reset or next accepted start_frame); writing continues unchanged.
- Not defined: bresp ignored, write_error tied 0.

## Test plan
- 16×16 frame, base 0x100, slave always ready, pixel value = raster index → AW addresses 0x100, 0x140, …, 0x2C0 (block 0), 0x120 first of block 1, 0x300 first of block 2; memory dump equals raster ramp; one frame_done; 32 AW handshakes.
- wready toggling 1/0 each cycle, awready delayed 3 cycles → wdata/awaddr stable while stalled, same memory image, wlast only on beat 7.
- pix_valid gapped (every 3rd cycle) → pix_ready low outside FILL, no pixel lost or duplicated; awvalid exactly 1 cycle after 8th pixel.
- start_frame pulsed while busy, and with frame_width=4 → both ignored, busy unchanged/0.
- bresp=2'b10 on burst 5 with WRITER_BRESP_CHECK_EN → write_error=1 from next cycle until next start_frame; without macro write_error stays 0.
- rst_n low during DATA beat 3 → all outputs 0 asynchronously; after release a new 16×16 frame completes correctly.

Source files
------------

// File: rtl/block_writer_axi.sv
// block_writer_axi: write-back end of the block pipeline.
// Takes the pixel stream in block order (BLOCK_SIZE x BLOCK_SIZE blocks,
// row-major inside a block, blocks raster-ordered) and writes each block row
// to frame memory as one AXI INCR burst, restoring raster layout.
// Optional feature: define WRITER_BRESP_CHECK_EN to flag non-OKAY B responses
// on write_error_o (sticky until reset or the next accepted start).
//
// state  | meaning
// S_IDLE | waiting for a start with a legal frame size
// S_FILL | collecting one block row into the row buffer
// S_ADDR | presenting the AW request for the buffered row
// S_DATA | streaming the row buffer on W, wlast on the final beat
// S_RESP | waiting for the single outstanding B response
// S_DONE | one-cycle frame_done pulse
module block_writer_axi #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_frame_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [15:0]             frame_width_i,
    input  logic [15:0]             frame_height_i,
    input  logic [DATA_WIDTH-1:0]   pix_data_i,
    input  logic                    pix_valid_i,
    output logic                    pix_ready_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic [7:0]              awlen_o,
    output logic [2:0]              awsize_o,
    output logic [1:0]              awburst_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wlast_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    write_error_o
);

    localparam int            IW       = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int            LB       = $clog2(BLOCK_SIZE);
    localparam int            SW       = DATA_WIDTH / 8;
    localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_SIZE - 1);
    localparam logic [31:0]   BS32     = 32'(BLOCK_SIZE);
    localparam logic [31:0]   BYTES32  = 32'(SW);
    localparam logic [7:0]    AXLEN    = 8'(BLOCK_SIZE - 1);
    localparam logic [2:0]    AXSIZE   = 3'($clog2(SW));
    localparam logic [15:0]   BS16     = 16'(BLOCK_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [15:0]             fw_q;
    logic [15:0]             fh_q;
    logic [IW-1:0]           r_q;
    logic [15:0]             bcol_q;
    logic [15:0]             brow_q;
    logic [IW-1:0]           idx_q;
    logic [DATA_WIDTH-1:0]   buf_q [BLOCK_SIZE];

    logic                    start_ok;
    logic                    pix_acc;
    logic                    w_hs;
    logic                    b_hs;
    logic                    r_last;
    logic                    col_last;
    logic                    row_last;
    logic [15:0]             cols_w;
    logic [15:0]             rows_w;
    logic [31:0]             row_pix;
    logic [31:0]             addr_off;
    logic [31:0]             addr_sum;

    assign start_ok = (state_q == S_IDLE) && start_frame_i &&
                      (frame_width_i >= BS16) && (frame_height_i >= BS16);
    assign pix_acc  = (state_q == S_FILL) && pix_valid_i;
    assign w_hs     = (state_q == S_DATA) && wready_i;
    assign b_hs     = (state_q == S_RESP) && bvalid_i;

    assign cols_w   = fw_q >> LB;
    assign rows_w   = fh_q >> LB;
    assign r_last   = (r_q == LAST_IDX);
    assign col_last = ((bcol_q + 16'd1) == cols_w);
    assign row_last = ((brow_q + 16'd1) == rows_w);

    // Byte address of the current block row, computed in 32 bits and truncated.
    assign row_pix  = 32'(brow_q) * BS32 + 32'(r_q);
    assign addr_off = (row_pix * 32'(fw_q) + 32'(bcol_q) * BS32) * BYTES32;
    assign addr_sum = 32'(base_q) + addr_off;

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all channel outputs; outputs idle at zero outside their state.
    always_comb begin
        state_d      = state_q;
        pix_ready_o  = 1'b0;
        awaddr_o     = '0;
        awlen_o      = '0;
        awsize_o     = '0;
        awburst_o    = '0;
        awvalid_o    = 1'b0;
        wdata_o      = '0;
        wstrb_o      = '0;
        wlast_o      = 1'b0;
        wvalid_o     = 1'b0;
        bready_o     = 1'b0;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_FILL;
            end
            S_FILL: begin
                busy_o      = 1'b1;
                pix_ready_o = 1'b1;
                if (pix_acc && (idx_q == LAST_IDX)) state_d = S_ADDR;
            end
            S_ADDR: begin
                busy_o    = 1'b1;
                awvalid_o = 1'b1;
                awaddr_o  = ADDR_WIDTH'(addr_sum);
                awlen_o   = AXLEN;
                awsize_o  = AXSIZE;
                awburst_o = 2'b01;
                if (awready_i) state_d = S_DATA;
            end
            S_DATA: begin
                busy_o   = 1'b1;
                wvalid_o = 1'b1;
                wdata_o  = buf_q[idx_q];
                wstrb_o  = '1;
                wlast_o  = (idx_q == LAST_IDX);
                if (wready_i && (idx_q == LAST_IDX)) state_d = S_RESP;
            end
            S_RESP: begin
                busy_o   = 1'b1;
                bready_o = 1'b1;
                if (bvalid_i) begin
                    state_d = (r_last && col_last && row_last) ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                frame_done_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame geometry latch and row/column/block-row position counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            fw_q   <= '0;
            fh_q   <= '0;
            r_q    <= '0;
            bcol_q <= '0;
            brow_q <= '0;
        end else if (start_ok) begin
            base_q <= base_addr_i;
            fw_q   <= frame_width_i;
            fh_q   <= frame_height_i;
            r_q    <= '0;
            bcol_q <= '0;
            brow_q <= '0;
        end else if (b_hs) begin
            r_q <= r_last ? '0 : r_q + IW'(1);
            if (r_last) begin
                if (col_last) begin
                    bcol_q <= '0;
                    brow_q <= row_last ? 16'd0 : brow_q + 16'd1;
                end else begin
                    bcol_q <= bcol_q + 16'd1;
                end
            end
        end
    end

    // Shared fill/beat index and the row buffer; the index returns to 0 after each row.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) buf_q[i] <= '0;
        end else if (start_ok) begin
            idx_q <= '0;
        end else if (pix_acc || w_hs) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            if (pix_acc) buf_q[idx_q] <= pix_data_i;
        end
    end

`ifdef WRITER_BRESP_CHECK_EN
    logic err_q;

    // Sticky error on any non-OKAY response; writing carries on regardless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (b_hs && (bresp_i != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign write_error_o = err_q;
`else
    logic unused_bresp;
    assign unused_bresp  = ^bresp_i;
    assign write_error_o = 1'b0;
`endif

endmodule
